semaforo_monitor: RTL
=====================

# semaforo_monitor

Passive protocol checker sitting on the consumer side of the `semaforo` light interface. It samples the two light outputs `A` and `B` plus the pedestrian button `bt` every clock, and tracks each light's phase. It flags illegal encodings, conflicting greens, illegal colour sequences and phase-duration errors against the `VERDE`/`AMARELO`/`VERMELHO` cycle budgets. It is instantiated alongside `semaforo` in testbenches and in the integration top as a run-time assertion block.

## Interface
- `VERDE`, 8'd3: required green duration of light A, in cycles (1..255)
- `AMARELO`, 8'd1: required yellow duration of light A, in cycles (1..255)
- `VERMELHO`, 8'd2: required red duration of light A, in cycles (1..255)
- `clk` input 1: system clock, rising edge
- `rst` input 1: reset; one clock, reset is asynchronous and active-high
- `bt` input 1: pedestrian button, same signal driven into `semaforo`
- `A` input 3: light A state, one-hot: 3'b100 red, 3'b010 yellow, 3'b001 green
- `B` input 3: light B state, same encoding
- `viol` output 1: one-cycle pulse on every sample containing a violation
- `err` output 1: sticky, set on first violation, cleared only by `rst`
- `err_code` output 3: code of the first violation; holds until `rst`
- `a_cycles` output 8: count of completed A red->green transitions, wraps 255->0

## Operation
- All inputs are sampled on the rising edge of `clk`. Each light has a registered current colour and a `valid` flag. Light A also has an 8-bit phase counter, saturating at 255, and a `bt_seen` flag.
- First sample after reset: it loads the colour and sets `valid`. No transition check is made. The duration check is disabled for this partial phase.
- Violation codes, checked every sample. The lowest code wins when several occur together:
  - 1: `A` or `B` not one-hot (including 3'b000)
  - 2: conflict, both `A` and `B` non-red in the same sample
  - 3: illegal transition on either light. Only G->Y, Y->R, R->G or no change are allowed.
  - 4: A overstay. The phase counter reaches limit+1 while the colour is unchanged.
  - 5: A short phase. A colour change occurs while count < limit for that colour. A green is exempt if `bt_seen`.
- Phase counting: the counter is 1 on the first sample of a colour and increments on each further sample of the same colour. On a legal change it reloads to 1.
- Code 4 fires once per phase, on the sample where the count becomes limit+1. It does not fire on every later sample.
- `bt_seen`: cleared on entry to green. It is set on any sample with `bt`=1 while A is green, including the entry sample.
- On a code-1 sample, that light's tracked state is not updated. On codes 2–5 the new colour is still adopted, so checking resynchronises.
- `a_cycles` increments on each A R->G transition. The first-sample load is not counted.
- Light B gets only the code 1/2/3 checks. There are no duration checks on B.
- Reset values: `viol`=0, `err`=0, `err_code`=3'd0, `a_cycles`=8'd0, both `valid`=0, counter=0, `bt_seen`=0.
- Reset mid-run clears everything immediately (asynchronous). The first sample after reset release is treated as the first sample.

## Timing
- Latency: a violation in the inputs sampled at edge k shows on `viol`/`err`/`err_code` right after edge k. `viol` drops after edge k+1 unless there is a new violation.
- `err_code` is written only when `err` is 0. Later violations pulse `viol` but do not change `err_code`.
- Purely synchronous checking. The block contains no combinational path from inputs to outputs.

## Test plan
- Nominal run, defaults: A = G,G,G,Y,R,R,G while B = R,R,R,R,G,G,R (B non-red only during A red). Required: `err`=0 throughout and `a_cycles`=1 after the final edge.
- Conflict: A=3'b001 and B=3'b010 at edge 4. Required: `viol`=1 for one cycle, `err`=1, `err_code`=2.
- Illegal transition: A goes G then R with no yellow. Required: `err_code`=3. A R->Y also yields 3.
- Button early green: with `bt`=1 for one edge during the first A green sample, A does G,Y. Required: no violation. The same sequence without `bt` gives `err_code`=5.
- Overstay and encoding: A stays yellow for 2 samples with `AMARELO`=1. Required: code 4 on the 2nd yellow sample. A separate run with A=3'b011 must give `err_code`=1.
- Reset mid-run: assert `rst` between edges after an error. Required: `err`, `err_code` and `a_cycles` go to 0 without waiting for a clock edge. The next sample acts as a first sample, so no code 3 is raised even if the colour differs.

Source files
------------

// File: rtl/semaforo_monitor.sv
`default_nettype none
// ============================================================================
// Module   : semaforo_monitor
// Purpose  : Passive run-time checker for the semaforo light outputs.
//            Tracks the colour and phase length of both lights. Reports
//            bad encodings, conflicting greens, illegal colour steps and
//            light-A phase-duration errors.
// Revision : 1.0 - initial release
// ============================================================================
module semaforo_monitor #(
  parameter logic [7:0] VERDE    = 8'd3,
  parameter logic [7:0] AMARELO  = 8'd1,
  parameter logic [7:0] VERMELHO = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic       viol,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] a_cycles
);

  // One-hot light colours, matching the semaforo output encoding
  typedef enum logic [2:0] {
    COL_RED = 3'b100,
    COL_YEL = 3'b010,
    COL_GRN = 3'b001
  } colour_t;

  // Violation codes; a lower value has priority
  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_ENC      = 3'd1;
  localparam logic [2:0] CODE_CONFLICT = 3'd2;
  localparam logic [2:0] CODE_SEQ      = 3'd3;
  localparam logic [2:0] CODE_LONG     = 3'd4;
  localparam logic [2:0] CODE_SHORT    = 3'd5;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  // Tracked state of light A
  colour_t    a_col, a_col_nxt;
  logic       a_valid, a_valid_nxt;
  logic [7:0] a_cnt, a_cnt_nxt;
  logic       a_full, a_full_nxt;   // current phase began after a real change
  logic       bt_seen, bt_seen_nxt;

  // Tracked state of light B
  colour_t    b_col, b_col_nxt;
  logic       b_valid, b_valid_nxt;

  // Registered outputs
  logic       viol_nxt;
  logic       err_nxt;
  logic [2:0] err_code_nxt;
  logic [7:0] a_cycles_nxt;

  // Per-sample check terms
  logic       a_ok, b_ok;
  logic       a_changed, b_changed;
  logic       enc_bad, conflict, seq_bad, long_bad, short_bad;
  logic       a_exempt;
  logic [7:0] a_limit;
  logic [7:0] a_cnt_inc;
  logic [2:0] code;

  // Allowed steps: G->Y, Y->R, R->G, or staying on the same colour
  function automatic logic step_ok(input colour_t prev, input logic [2:0] cur);
    case (prev)
      COL_GRN: step_ok = (cur == COL_GRN) || (cur == COL_YEL);
      COL_YEL: step_ok = (cur == COL_YEL) || (cur == COL_RED);
      COL_RED: step_ok = (cur == COL_RED) || (cur == COL_GRN);
      default: step_ok = 1'b0;
    endcase
  endfunction

  // Required phase length of light A for a given colour
  function automatic logic [7:0] colour_limit(input colour_t c);
    case (c)
      COL_GRN: colour_limit = VERDE;
      COL_YEL: colour_limit = AMARELO;
      default: colour_limit = VERMELHO;
    endcase
  endfunction

  // Evaluate this sample's violations and the next tracking state
  always_comb begin
    a_col_nxt    = a_col;
    a_valid_nxt  = a_valid;
    a_cnt_nxt    = a_cnt;
    a_full_nxt   = a_full;
    bt_seen_nxt  = bt_seen;
    b_col_nxt    = b_col;
    b_valid_nxt  = b_valid;
    a_cycles_nxt = a_cycles;
    code         = CODE_NONE;

    a_ok      = $onehot(A);
    b_ok      = $onehot(B);
    enc_bad   = !a_ok || !b_ok;
    conflict  = (A != COL_RED) && (B != COL_RED);
    a_changed = a_valid && a_ok && (A != a_col);
    b_changed = b_valid && b_ok && (B != b_col);
    seq_bad   = (a_changed && !step_ok(a_col, A)) ||
                (b_changed && !step_ok(b_col, B));

    a_limit   = colour_limit(a_col);
    a_cnt_inc = (a_cnt == CNT_MAX) ? CNT_MAX : a_cnt + 8'd1;

    // Overstay fires only on the sample where the count first passes the
    // limit; with a limit of 255 the saturating counter never gets there.
    long_bad  = a_valid && a_ok && !a_changed && a_full &&
                ({1'b0, a_cnt_inc} == ({1'b0, a_limit} + 9'd1));

    // A pedestrian request legitimately shortens green
    a_exempt  = (a_col == COL_GRN) && bt_seen;
    short_bad = a_changed && a_full && (a_cnt < a_limit) && !a_exempt;

    if (enc_bad) begin
      code = CODE_ENC;
    end else if (conflict) begin
      code = CODE_CONFLICT;
    end else if (seq_bad) begin
      code = CODE_SEQ;
    end else if (long_bad) begin
      code = CODE_LONG;
    end else if (short_bad) begin
      code = CODE_SHORT;
    end

    // Light A: a bad encoding leaves the tracked state untouched; any other
    // sample is adopted so checking resynchronises after a violation.
    if (a_ok) begin
      if (!a_valid) begin
        a_valid_nxt = 1'b1;
        a_col_nxt   = colour_t'(A);
        a_cnt_nxt   = 8'd1;
        a_full_nxt  = 1'b0;
        bt_seen_nxt = (A == COL_GRN) && bt;
      end else if (a_changed) begin
        a_col_nxt   = colour_t'(A);
        a_cnt_nxt   = 8'd1;
        a_full_nxt  = 1'b1;
        bt_seen_nxt = (A == COL_GRN) && bt;
        if ((a_col == COL_RED) && (A == COL_GRN)) begin
          a_cycles_nxt = a_cycles + 8'd1;
        end
      end else begin
        a_cnt_nxt = a_cnt_inc;
        if ((a_col == COL_GRN) && bt) begin
          bt_seen_nxt = 1'b1;
        end
      end
    end

    // Light B: colour tracking only, no duration accounting
    if (b_ok) begin
      b_valid_nxt = 1'b1;
      b_col_nxt   = colour_t'(B);
    end

    viol_nxt     = (code != CODE_NONE);
    err_nxt      = err || viol_nxt;
    err_code_nxt = (!err && viol_nxt) ? code : err_code;
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_col    <= COL_RED;
      a_valid  <= 1'b0;
      a_cnt    <= 8'd0;
      a_full   <= 1'b0;
      bt_seen  <= 1'b0;
      b_col    <= COL_RED;
      b_valid  <= 1'b0;
      viol     <= 1'b0;
      err      <= 1'b0;
      err_code <= CODE_NONE;
      a_cycles <= 8'd0;
    end else begin
      a_col    <= a_col_nxt;
      a_valid  <= a_valid_nxt;
      a_cnt    <= a_cnt_nxt;
      a_full   <= a_full_nxt;
      bt_seen  <= bt_seen_nxt;
      b_col    <= b_col_nxt;
      b_valid  <= b_valid_nxt;
      viol     <= viol_nxt;
      err      <= err_nxt;
      err_code <= err_code_nxt;
      a_cycles <= a_cycles_nxt;
    end
  end

endmodule
`default_nettype wire
